// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte handshake and status between a command source and ps2_host_tx.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;
    modport master (output tx_data, tx_valid, input tx_ready, busy, done, error);
    modport slave (input tx_data, tx_valid, output tx_ready, busy, done, error);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain clock/data enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_c_in,
    input  logic         ps2_d_in,
    output logic         ps2_c_oe,
    output logic         ps2_d_oe
);
    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] INHIBIT = 4'd1;
    localparam logic [3:0] START = 4'd2;
    localparam logic [3:0] REQ = 4'd3;
    localparam logic [3:0] DATA = 4'd4;
    localparam logic [3:0] STOP = 4'd5;
    localparam logic [3:0] ACK_WAIT = 4'd6;
    localparam logic [3:0] DONE = 4'd7;
    localparam logic [3:0] ERR = 4'd8;
    logic [3:0] state_q, state_d;
    logic [1:0] c_sync_q, c_sync_d, d_sync_q, d_sync_d;
    logic c_prev_q, c_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [8:0] shift_q, shift_d;
    logic c_oe_q, c_oe_d, d_oe_q, d_oe_d, done_q, done_d, error_q, error_d;
    logic fe, watched;
    always_comb begin
        c_sync_d = {c_sync_q[0], ps2_c_in};
        d_sync_d = {d_sync_q[0], ps2_d_in};
        c_prev_d = c_sync_q[1];
        fe = c_prev_q & ~c_sync_q[1];
        watched = state_q inside {REQ, DATA, STOP, ACK_WAIT};
        state_d = state_q;
        shift_d = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (watched && cnt_q == TO_LAST) state_d = ERR;
        else case (state_q)
            IDLE: if (bus.tx_valid) begin
                state_d = INHIBIT;
                shift_d = {~^bus.tx_data, bus.tx_data};
            end
            INHIBIT: state_d = (cnt_q == INH_LAST) ? START : INHIBIT;
            START: state_d = REQ;
            REQ: if (fe) begin
                state_d = DATA;
                bit_cnt_d = 4'd0;
            end
            DATA: if (fe) begin
                state_d = (bit_cnt_q == 4'd8) ? STOP : DATA;
                shift_d = (bit_cnt_q == 4'd8) ? shift_q : shift_q >> 1;
                bit_cnt_d = (bit_cnt_q == 4'd8) ? bit_cnt_q : bit_cnt_q + 4'd1;
            end
            STOP: if (fe) state_d = d_sync_q[1] ? ERR : ACK_WAIT;
            ACK_WAIT: state_d = (c_sync_q[1] && d_sync_q[1]) ? DONE : ACK_WAIT;
            default: state_d = IDLE;
        endcase
        // our own clock pull-down during INHIBIT creates edges that must not restart the hold
        cnt_d = (state_d != state_q || (fe && state_q != INHIBIT) || !(watched || state_q == INHIBIT))
                ? '0 : cnt_q + CW'(1);
        c_oe_d = state_d == INHIBIT || state_d == START;
        d_oe_d = (state_d == START || state_d == REQ) ? 1'b1 : (state_d == DATA) ? ~shift_d[0] : 1'b0;
        done_d = state_d == DONE;
        error_d = state_d == ERR;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            c_prev_q <= 1'b1;
            cnt_q <= '0;
            bit_cnt_q <= 4'd0;
            shift_q <= 9'd0;
            c_oe_q <= 1'b0;
            d_oe_q <= 1'b0;
            done_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            c_prev_q <= c_prev_d;
            cnt_q <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q <= shift_d;
            c_oe_q <= c_oe_d;
            d_oe_q <= d_oe_d;
            done_q <= done_d;
            error_q <= error_d;
        end
    end
    assign bus.tx_ready = state_q == IDLE;
    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
    assign bus.error = error_q;
    assign ps2_c_oe = c_oe_q;
    assign ps2_d_oe = d_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against an open-drain PS/2 device model and checks frames and timing.
module tb_ps2_host_tx;
    localparam int INH = 60;
    localparam int TO = 1000;
    localparam int H = 20;
    logic clk = 1'b0, rst = 1'b1, dev_c = 1'b1, dev_d = 1'b1;
    logic c_oe, d_oe, c_line, d_line;
    int n_checks = 0, n_fail = 0, n_done = 0, n_err = 0, cyc = 0, err_cyc = 0, last_fall = 0;
    bit both = 1'b0;
    ps2_host_tx_if bus ();
    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ps2_c_in(c_line), .ps2_d_in(d_line),
        .ps2_c_oe(c_oe), .ps2_d_oe(d_oe));
    assign c_line = ~c_oe & dev_c;
    assign d_line = ~d_oe & dev_d;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.done === 1'b1) n_done <= n_done + 1;
        if (bus.error === 1'b1) begin
            n_err <= n_err + 1;
            err_cyc <= cyc;
        end
        if (bus.done === 1'b1 && bus.error === 1'b1) both <= 1'b1;
    end
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2) == 0;
        return {1'b1, par, b, 1'b0};
    endfunction
    task automatic send(input logic [7:0] b, output bit ok);
        int w = 0;
        @(negedge clk);
        bus.tx_data = b;
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        ok = bus.tx_ready === 1'b1;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
    endtask
    // device: sees the start bit while the host holds data low, then clocks and samples on rising edges
    task automatic device(input bit ack, input int stop_after, output logic [10:0] bits, output int lat, output bit ok);
        int w = 0;
        bits = '1;
        lat = -1;
        ok = 1'b1;
        while (!(c_oe === 1'b0 && d_oe === 1'b1) && w < 5 * INH) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5 * INH) begin
            ok = 1'b0;
            return;
        end
        bits[0] = d_line;
        for (int i = 1; i <= 11; i++) begin
            if (stop_after != 0 && i > stop_after) break;
            if (i == 11 && ack) dev_d = 1'b0;
            repeat (H) @(negedge clk);
            dev_c = 1'b0;
            last_fall = cyc;
            for (int k = 1; k <= H; k++) begin
                @(negedge clk);
                if (i == 1 && lat < 0 && d_oe === 1'b0) lat = k;
            end
            dev_c = 1'b1;
            if (i <= 10) bits[i] = d_line;
        end
        repeat (2) @(negedge clk);
        dev_d = 1'b1;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if (c_oe !== 1'b0) begin n_fail++; $display("FAIL reset_c_oe got %b want 0", c_oe); end
        n_checks++; if (d_oe !== 1'b0) begin n_fail++; $display("FAIL reset_d_oe got %b want 0", d_oe); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", bus.error); end
        n_checks++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got %b want 1", bus.tx_ready); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask
    task automatic test_f4_timing;
        logic [10:0] bits;
        int lat, d_first = -1, c_fall = -1, low = 0, d0 = n_done, e0 = n_err;
        bit ok, ok2;
        send(8'hF4, ok);
        for (int k = 1; k <= INH + 3; k++) begin
            @(negedge clk);
            if (c_oe === 1'b1) low++;
            if (d_first < 0 && d_oe === 1'b1) d_first = k;
            if (c_fall < 0 && k > 1 && c_oe === 1'b0) c_fall = k;
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL f4_accept got tx_ready=0 want 1"); end
        n_checks++; if (low !== INH + 1) begin n_fail++; $display("FAIL f4_clock_low got %0d want %0d", low, INH + 1); end
        n_checks++; if (d_first !== INH + 1) begin n_fail++; $display("FAIL f4_d_oe_rise got %0d want %0d", d_first, INH + 1); end
        n_checks++; if (c_fall !== INH + 2) begin n_fail++; $display("FAIL f4_c_oe_fall got %0d want %0d", c_fall, INH + 2); end
        device(1'b1, 0, bits, lat, ok2);
        repeat (10) @(negedge clk);
        n_checks++; if (!ok2) begin n_fail++; $display("FAIL f4_req got no request want request"); end
        n_checks++; if (bits !== frame_of(8'hF4)) begin n_fail++; $display("FAIL f4_bits got %b want %b", bits, frame_of(8'hF4)); end
        n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL f4_done got %0d want 1", n_done - d0); end
        n_checks++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL f4_error got %0d want 0", n_err - e0); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL f4_busy_after got %b want 0", bus.busy); end
    endtask
    task automatic test_frames;
        logic [7:0] pat [6];
        logic [10:0] bits;
        int lat, d0;
        bit ok, ok2;
        pat[0] = 8'hED;
        pat[1] = 8'h00;
        for (int j = 2; j < 6; j++) pat[j] = 8'($urandom);
        for (int j = 0; j < 6; j++) begin
            d0 = n_done;
            send(pat[j], ok);
            device(1'b1, 0, bits, lat, ok2);
            repeat (10) @(negedge clk);
            n_checks++; if (bits !== frame_of(pat[j])) begin n_fail++; $display("FAIL frame_%02h got %b want %b", pat[j], bits, frame_of(pat[j])); end
            n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL frame_%02h_done got %0d want 1", pat[j], n_done - d0); end
            if (pat[j][0]) begin
                n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL frame_%02h_latency got %0d want 3", pat[j], lat); end
            end
        end
    endtask
    task automatic test_no_ack;
        logic [10:0] bits;
        int lat, d0 = n_done, e0 = n_err;
        bit ok, ok2;
        send(8'($urandom), ok);
        device(1'b0, 0, bits, lat, ok2);
        repeat (10) @(negedge clk);
        n_checks++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL noack_error got %0d want 1", n_err - e0); end
        n_checks++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL noack_done got %0d want 0", n_done - d0); end
        n_checks++; if (c_oe !== 1'b0 || d_oe !== 1'b0) begin n_fail++; $display("FAIL noack_lines got %b%b want 00", c_oe, d_oe); end
        n_checks++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL noack_tx_ready got %b want 1", bus.tx_ready); end
    endtask
    task automatic test_timeout;
        logic [10:0] bits;
        int lat, w = 0, d0 = n_done, e0 = n_err;
        bit ok, ok2;
        send(8'($urandom), ok);
        device(1'b1, 4, bits, lat, ok2);
        while (n_err == e0 && w < TO + 50) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        n_checks++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL timeout_error got %0d want 1", n_err - e0); end
        n_checks++; if (err_cyc - last_fall !== TO + 3) begin n_fail++; $display("FAIL timeout_delay got %0d want %0d", err_cyc - last_fall, TO + 3); end
        n_checks++; if (c_oe !== 1'b0 || d_oe !== 1'b0) begin n_fail++; $display("FAIL timeout_lines got %b%b want 00", c_oe, d_oe); end
        n_checks++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL timeout_done got %0d want 0", n_done - d0); end
    endtask
    task automatic test_back_to_back;
        logic [10:0] bits;
        logic [7:0] b;
        int lat, idle = 0, d0 = n_done;
        bit ok, ok2, ignored = 1'b1;
        b = 8'($urandom);
        send(b, ok);
        repeat (5) @(negedge clk);
        bus.tx_data = 8'h11;
        bus.tx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.tx_ready !== 1'b0 || bus.busy !== 1'b1) ignored = 1'b0;
        end
        bus.tx_valid = 1'b0;
        n_checks++; if (!ignored) begin n_fail++; $display("FAIL busy_handshake got ready/busy wrong want ready=0 busy=1"); end
        device(1'b1, 0, bits, lat, ok2);
        repeat (10) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0 && c_oe === 1'b0) idle++;
        end
        n_checks++; if (bits !== frame_of(b)) begin n_fail++; $display("FAIL busy_frame got %b want %b", bits, frame_of(b)); end
        n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL busy_done got %0d want 1", n_done - d0); end
        n_checks++; if (idle !== 5) begin n_fail++; $display("FAIL busy_not_queued got %0d idle cycles want 5", idle); end
        send(8'hFF, ok);
        device(1'b1, 0, bits, lat, ok2);
        repeat (10) @(negedge clk);
        n_checks++; if (bits !== frame_of(8'hFF)) begin n_fail++; $display("FAIL ff_frame got %b want %b", bits, frame_of(8'hFF)); end
        n_checks++; if (bits[9] !== 1'b1) begin n_fail++; $display("FAIL ff_parity got %b want 1", bits[9]); end
        n_checks++; if (n_done - d0 !== 2) begin n_fail++; $display("FAIL ff_done got %0d want 2", n_done - d0); end
    endtask
    task automatic test_reset_mid;
        logic [10:0] bits;
        int lat, d0 = n_done, e0 = n_err;
        bit ok, ok2;
        send(8'hE4, ok);
        device(1'b1, 5, bits, lat, ok2);
        n_checks++; if (d_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_bit4 got d_oe=%b want 1", d_oe); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (c_oe !== 1'b0 || d_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_lines got %b%b want 00", c_oe, d_oe); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (n_done !== d0 || n_err !== e0) begin n_fail++; $display("FAIL rstmid_pulses got done+%0d err+%0d want 0 0", n_done - d0, n_err - e0); end
        send(8'hF4, ok);
        device(1'b1, 0, bits, lat, ok2);
        repeat (10) @(negedge clk);
        n_checks++; if (bits !== frame_of(8'hF4)) begin n_fail++; $display("FAIL rstmid_next_frame got %b want %b", bits, frame_of(8'hF4)); end
        n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL rstmid_next_done got %0d want 1", n_done - d0); end
    endtask
    task automatic test_exclusive;
        n_checks++; if (both !== 1'b0) begin n_fail++; $display("FAIL done_error_overlap got %b want 0", both); end
    endtask
    initial begin
        test_reset;
        test_f4_timing;
        test_frames;
        test_no_ack;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_exclusive;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish before 50000 cycles");
        $fatal(1, "bench time limit reached");
    end
endmodule
